unpadding: RTL and testbench

- Strips a one-pixel zero border from a padded 8-bit grayscale stream: (IMG_WIDTH+2) x (IMG_HEIGHT+2) bytes in, IMG_WIDTH x IMG_HEIGHT bytes out.
- Undoes the border-insertion stage, placed at the consumer end of the sobel pipeline, before image write-back/compare.
- FIFO in, FIFO out, first-word-fall-through reads; frames arrive back-to-back with no delimiters.

---
 rtl/unpadding.sv | 118 +++++++++++
 tb/tb_unpadding.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/unpadding.sv
`default_nettype none
// ============================================================================
// Module   : unpadding
// Brief    : Strips a one-pixel border from a padded FWFT byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module unpadding #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic       clock,
  input  logic       reset,
  output logic       in_rd_en,
  input  logic [7:0] in_dout,
  input  logic       in_empty,
  output logic       out_wr_en,
  output logic [7:0] out_din,
  input  logic       out_full,
  output logic       frame_done
);

  localparam logic [12:0] c_x_last = 13'(IMG_WIDTH + 1);
  localparam logic [12:0] c_y_mid_last = 13'(IMG_HEIGHT);

  typedef enum logic [1:0] {
    S_TOP     = 2'b00,
    S_MID     = 2'b01,
    S_BOT     = 2'b10,
    S_ILLEGAL = 2'b11
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [12:0] r_x;
  logic [12:0] r_y;
  logic [12:0] w_x_next;
  logic [12:0] w_y_next;
  logic        r_frame_done;
  logic        w_frame_done_next;
  logic        w_row_end;
  logic        w_keep_pos;

  assign out_din    = in_dout;
  assign frame_done = r_frame_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_TOP;
      r_x          <= 13'd0;
      r_y          <= 13'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_x          <= w_x_next;
      r_y          <= w_y_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  always_comb begin
    w_row_end         = (r_x == c_x_last);
    w_keep_pos        = (r_state == S_MID) && (r_x != 13'd0) && !w_row_end;
    in_rd_en          = 1'b0;
    out_wr_en         = 1'b0;
    w_state_next      = r_state;
    w_x_next          = r_x;
    w_y_next          = r_y;
    w_frame_done_next = 1'b0;

    // Keep positions must never pop without pushing, so they also wait on out_full.
    if (!reset) begin
      case (r_state)
        S_TOP, S_BOT: in_rd_en = !in_empty;
        S_MID: begin
          if (w_keep_pos) begin
            in_rd_en  = !in_empty && !out_full;
            out_wr_en = !in_empty && !out_full;
          end else begin
            in_rd_en = !in_empty;
          end
        end
        default: in_rd_en = 1'b0;
      endcase
    end

    if (r_state == S_ILLEGAL) begin
      w_state_next = S_TOP;
      w_x_next     = 13'd0;
      w_y_next     = 13'd0;
    end else if (in_rd_en) begin
      if (!w_row_end) begin
        w_x_next = r_x + 13'd1;
      end else begin
        w_x_next = 13'd0;
        case (r_state)
          S_TOP: begin
            w_y_next     = 13'd1;
            w_state_next = S_MID;
          end
          S_MID: begin
            w_y_next = r_y + 13'd1;
            if (r_y == c_y_mid_last) begin
              w_state_next = S_BOT;
            end
          end
          S_BOT: begin
            w_y_next          = 13'd0;
            w_state_next      = S_TOP;
            w_frame_done_next = 1'b1;
          end
          default: w_state_next = S_TOP;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unpadding.sv
`default_nettype none
// ============================================================================
// Module   : tb_unpadding
// Brief    : Scoreboard bench for unpadding on a 4x3 image (6x5 padded).
// Revision : 1.0 - initial release
// ============================================================================
module tb_unpadding;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = W + 2;
  localparam int PH = H + 2;
  localparam int FB = PW * PH;

  logic       clock;
  logic       reset;
  logic       in_rd_en;
  logic [7:0] in_dout;
  logic       in_empty;
  logic       out_wr_en;
  logic [7:0] out_din;
  logic       out_full;
  logic       frame_done;

  unpadding #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_rd_en   (in_rd_en),
    .in_dout    (in_dout),
    .in_empty   (in_empty),
    .out_wr_en  (out_wr_en),
    .out_din    (out_din),
    .out_full   (out_full),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] in_q[$];
  logic [7:0] sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  pos = 0;
  bit  done_pend = 1'b0;
  bit  pop_now = 1'b0;
  bit  starve = 1'b0;
  bit  full_arm = 1'b0;
  int  full_cnt = 0;
  logic       exp_keep, exp_rd, exp_wr, exp_done;
  logic [7:0] exp_data;
  logic [7:0] tmp;

  // Input FIFO model plus out_full generator, updated just after each edge.
  always @(posedge clock) begin
    #1;
    if (pop_now && in_q.size() > 0) tmp = in_q.pop_front();
    pop_now = 1'b0;
    if (full_cnt > 0) full_cnt--;
    if (full_arm && pos == 11) begin
      full_cnt = 10;
      full_arm = 1'b0;
    end
    out_full = (full_cnt > 0);
    in_empty = (in_q.size() == 0) || (starve && $urandom_range(0, 1) == 1);
    in_dout  = (in_q.size() > 0) ? in_q[0] : 8'h00;
  end

  // Positional reference model and output checks, mid-cycle.
  always @(negedge clock) begin
    exp_keep = (pos / PW >= 1) && (pos / PW <= H) && (pos % PW >= 1) && (pos % PW <= W);
    exp_rd   = !reset && !in_empty && (!exp_keep || !out_full);
    exp_wr   = exp_rd && exp_keep;
    exp_done = done_pend;

    n_cmp++;
    assert (in_rd_en === exp_rd) else begin
      n_err++;
      $error("FAIL rd_en pos=%0d observed=%b expected=%b", pos, in_rd_en, exp_rd);
    end
    n_cmp++;
    assert (out_wr_en === exp_wr) else begin
      n_err++;
      $error("FAIL wr_en pos=%0d observed=%b expected=%b", pos, out_wr_en, exp_wr);
    end
    n_cmp++;
    assert (frame_done === exp_done) else begin
      n_err++;
      $error("FAIL frame_done pos=%0d observed=%b expected=%b", pos, frame_done, exp_done);
    end

    if (out_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL extra_push observed=%0d expected=none", out_din);
      end else begin
        exp_data = sb.pop_front();
        n_cmp++;
        assert (out_din === exp_data) else begin
          n_err++;
          $error("FAIL data observed=%0d expected=%0d", out_din, exp_data);
        end
      end
    end

    pop_now = (in_rd_en === 1'b1);

    if (reset) begin
      pos       = 0;
      done_pend = 1'b0;
    end else if (exp_rd) begin
      done_pend = (pos == FB - 1);
      pos       = (pos == FB - 1) ? 0 : pos + 1;
    end else begin
      done_pend = 1'b0;
    end
  end

  task automatic load_frame(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      int r, c;
      r = i / PW;
      c = i % PW;
      if (r >= 1 && r <= H && c >= 1 && c <= W) begin
        in_q.push_back(8'(base + (r - 1) * W + c));
        sb.push_back(8'(base + (r - 1) * W + c));
      end else begin
        in_q.push_back(8'hFF);
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int t;
    t = 0;
    while (in_q.size() > 0 && t < max_cycles) begin
      @(posedge clock);
      t++;
    end
    repeat (3) @(posedge clock);
    n_cmp++;
    assert (in_q.size() == 0) else begin
      n_err++;
      $error("FAIL %s_drain observed=%0d left expected=0", tag, in_q.size());
    end
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL %s_pushes observed=%0d missing expected=0", tag, sb.size());
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_empty = 1'b1;
    in_dout  = 8'h00;
    out_full = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    load_frame(0, FB);
    wait_idle("basic", 200);

    load_frame(0, FB);
    load_frame(100, FB);
    wait_idle("b2b", 300);

    full_arm = 1'b1;
    load_frame(0, FB);
    wait_idle("backpressure", 300);

    starve = 1'b1;
    load_frame(0, FB);
    wait_idle("starve", 400);
    starve = 1'b0;

    load_frame(0, 17);
    wait_idle("partial", 200);
    @(posedge clock);
    #2 reset = 1'b1;
    load_frame(50, FB);
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    wait_idle("after_reset", 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
